// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_pkg                                                        |
// | Purpose  : Shared opcode/funct constants, FSM state and mux encodings.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_jr_funct_default     = 6'b001000;
  localparam logic [5:0] c_addiu_opcode_default = 6'b001001;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_LW_WB    = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_ADDI_EX  = 4'd9,
    ST_ADDI_WB  = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_HALT     = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG_A  = 2'b11
  } pc_source_t;

  typedef enum logic [1:0] {
    SRCB_B        = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } alu_src_b_t;

endpackage

`default_nettype wire

// File: rtl/mips_main_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_main_decoder                                               |
// | Purpose  : Combinational opcode classifier used for DECODE/EXEC branching. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mips_main_decoder
  import mips_pkg::*;
#(
  parameter logic [5:0] ADDIU_OPCODE = c_addiu_opcode_default
) (
  input  logic [5:0] opcode,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_addiu,
  output logic       illegal
);

  assign is_r     = (opcode == c_op_rtype);
  assign is_lw    = (opcode == c_op_lw);
  assign is_sw    = (opcode == c_op_sw);
  assign is_beq   = (opcode == c_op_beq);
  assign is_j     = (opcode == c_op_j);
  assign is_addiu = (opcode == ADDIU_OPCODE);
  assign illegal  = !(is_r || is_lw || is_sw || is_beq || is_j || is_addiu);

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_multicycle_ctrl                                            |
// | Purpose  : Multi-cycle MIPS sequencer driving datapath selects and memory. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter logic [5:0] JR_FUNCT     = c_jr_funct_default,
  parameter logic [5:0] ADDIU_OPCODE = c_addiu_opcode_default
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] instr_opcode,
  input  logic [5:0] instr_funct,
  input  logic       jr_target_zero,
  input  logic       waitrequest,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal_opcode,
  output logic       active
);

  state_t r_state;

  logic w_is_r;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_j;
  logic w_is_addiu;
  logic w_illegal;
  logic w_is_jr;

  mips_main_decoder #(
    .ADDIU_OPCODE (ADDIU_OPCODE)
  ) u_main_decoder (
    .opcode   (instr_opcode),
    .is_r     (w_is_r),
    .is_lw    (w_is_lw),
    .is_sw    (w_is_sw),
    .is_beq   (w_is_beq),
    .is_j     (w_is_j),
    .is_addiu (w_is_addiu),
    .illegal  (w_illegal)
  );

  assign w_is_jr = (instr_funct == JR_FUNCT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     r_state <= ST_FETCH;
        ST_FETCH:    if (!waitrequest) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_is_r)                  r_state <= ST_EXEC_R;
          else if (w_is_lw || w_is_sw) r_state <= ST_MEM_ADDR;
          else if (w_is_addiu)         r_state <= ST_ADDI_EX;
          else if (w_is_beq)           r_state <= ST_BRANCH;
          else if (w_is_j)             r_state <= ST_JUMP;
          else                         r_state <= ST_FETCH;
        end
        ST_EXEC_R: begin
          if (w_is_jr) r_state <= jr_target_zero ? ST_HALT : ST_FETCH;
          else         r_state <= ST_R_WB;
        end
        ST_R_WB:     r_state <= ST_FETCH;
        ST_MEM_ADDR: r_state <= w_is_lw ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (!waitrequest) r_state <= ST_LW_WB;
        ST_LW_WB:    r_state <= ST_FETCH;
        ST_MEM_WR:   if (!waitrequest) r_state <= ST_FETCH;
        ST_ADDI_EX:  r_state <= ST_ADDI_WB;
        ST_ADDI_WB:  r_state <= ST_FETCH;
        ST_BRANCH:   r_state <= ST_FETCH;
        ST_JUMP:     r_state <= ST_FETCH;
        ST_HALT:     r_state <= ST_HALT;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register so an async reset clears
  // any in-flight bus request in the same cycle.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    iord           = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    pc_source      = PC_ALU;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_B;
    alu_op         = ALU_ADD;
    reg_dst        = 1'b0;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    illegal_opcode = 1'b0;
    active         = (r_state != ST_IDLE) && (r_state != ST_HALT);
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = !waitrequest;
        pc_write  = !waitrequest;
      end
      ST_DECODE: begin
        alu_src_b      = SRCB_IMM_SHL2;
        illegal_opcode = w_illegal;
      end
      ST_EXEC_R: begin
        if (w_is_jr) begin
          pc_write  = 1'b1;
          pc_source = PC_REG_A;
        end else begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_mips_multicycle_ctrl                                         |
// | Purpose  : Self-checking bench for the multi-cycle MIPS sequencer.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] instr_opcode = '0;
  logic [5:0] instr_funct = '0;
  logic       jr_target_zero = 1'b0;
  logic       waitrequest = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, reg_write, mem_to_reg, illegal_opcode, active;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst, reg_write, mem_to_reg, illegal_opcode, active;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic fixed;
    logic val;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       jz;
    int         fw;
    int         mw;
    int         cyc;
    int         rw;
    int         mrd;
    int         mwr;
    int         ill;
    logic       halt;
  } row_t;

  ctl_t  dut_ctl;
  step_t exp_q[$];
  row_t  rows[10];

  assign dut_ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                    alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg,
                    illegal_opcode, active};

  mips_multicycle_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_opcode   (instr_opcode),
    .instr_funct    (instr_funct),
    .jr_target_zero (jr_target_zero),
    .waitrequest    (waitrequest),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .iord           (iord),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .pc_source      (pc_source),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .alu_op         (alu_op),
    .reg_dst        (reg_dst),
    .reg_write      (reg_write),
    .mem_to_reg     (mem_to_reg),
    .illegal_opcode (illegal_opcode),
    .active         (active)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h09 || op == 6'h04 || op == 6'h02;
  endfunction

  function automatic ctl_t busy();
    ctl_t c;
    c = '0;
    c.active = 1'b1;
    return c;
  endfunction

  // Expected per-cycle control words of one instruction, starting at its fetch.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    ctl_t c;
    exp_q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = busy(); c.mem_read = 1'b1; c.alu_src_b = 2'b01;
      if (i == fw) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      exp_q.push_back({c, 1'b1, (i < fw)});
    end
    c = busy(); c.alu_src_b = 2'b11; c.illegal_opcode = !legal(op);
    exp_q.push_back({c, 2'b00});
    if (op == 6'h00 && fn == 6'h08) begin
      c = busy(); c.pc_write = 1'b1; c.pc_source = 2'b11;
      exp_q.push_back({c, 2'b00});
    end else if (op == 6'h00) begin
      c = busy(); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
      exp_q.push_back({c, 2'b00});
      c = busy(); c.reg_write = 1'b1; c.reg_dst = 1'b1;
      exp_q.push_back({c, 2'b00});
    end else if (op == 6'h23 || op == 6'h2B || op == 6'h09) begin
      c = busy(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      exp_q.push_back({c, 2'b00});
      if (op == 6'h09) begin
        c = busy(); c.reg_write = 1'b1;
        exp_q.push_back({c, 2'b00});
      end else begin
        for (int i = 0; i <= mw; i++) begin
          c = busy(); c.iord = 1'b1;
          if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
          exp_q.push_back({c, 1'b1, (i < mw)});
        end
        if (op == 6'h23) begin
          c = busy(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          exp_q.push_back({c, 2'b00});
        end
      end
    end else if (op == 6'h04) begin
      c = busy(); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      exp_q.push_back({c, 2'b00});
    end else if (op == 6'h02) begin
      c = busy(); c.pc_write = 1'b1; c.pc_source = 2'b10;
      exp_q.push_back({c, 2'b00});
    end
  endtask

  // Reactive memory: each request is stalled for the row's wait count.
  task automatic run_row(input string name, input row_t r);
    int cyc, rw, mrd, mwr, ill, req;
    logic halted, stalled_fetch, done;
    instr_opcode = r.op; instr_funct = r.fn; jr_target_zero = r.jz;
    cyc = 0; rw = 0; mrd = 0; mwr = 0; ill = 0; req = 0; halted = 0; done = 0;
    while (!done && cyc < 40) begin
      if (mem_read || mem_write) waitrequest = (req < (iord ? r.mw : r.fw));
      else waitrequest = 1'($urandom_range(0, 1));
      #4;
      rw += int'(reg_write); mrd += int'(mem_read); mwr += int'(mem_write);
      ill += int'(illegal_opcode);
      stalled_fetch = mem_read && !iord && waitrequest;
      req = ((mem_read || mem_write) && waitrequest) ? req + 1 : 0;
      cyc++;
      tick();
      if (!active) begin halted = 1'b1; done = 1'b1; end
      else if (mem_read && !iord && !stalled_fetch) done = 1'b1;
    end
    chk({name, "_cycles"}, cyc, r.cyc);
    chk({name, "_reg_write"}, rw, r.rw);
    chk({name, "_mem_read"}, mrd, r.mrd);
    chk({name, "_mem_write"}, mwr, r.mwr);
    chk({name, "_illegal"}, ill, r.ill);
    chk({name, "_halt"}, halted, r.halt);
  endtask

  initial begin
    //          op     fn     jz   fw mw cyc rw mrd mwr ill halt
    rows[0] = '{6'h00, 6'h21, 1'b0, 0, 0, 4, 1, 1, 0, 0, 1'b0};  // add
    rows[1] = '{6'h23, 6'h00, 1'b0, 0, 3, 8, 1, 5, 0, 0, 1'b0};  // lw, 3 waits
    rows[2] = '{6'h2B, 6'h00, 1'b0, 1, 2, 7, 0, 2, 3, 0, 1'b0};  // sw
    rows[3] = '{6'h09, 6'h00, 1'b0, 2, 0, 6, 1, 3, 0, 0, 1'b0};  // addiu
    rows[4] = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 0, 1, 0, 0, 1'b0};  // beq
    rows[5] = '{6'h02, 6'h00, 1'b0, 1, 0, 4, 0, 2, 0, 0, 1'b0};  // j
    rows[6] = '{6'h3F, 6'h00, 1'b0, 0, 0, 2, 0, 1, 0, 1, 1'b0};  // illegal
    rows[7] = '{6'h00, 6'h08, 1'b0, 0, 0, 3, 0, 1, 0, 0, 1'b0};  // jr nonzero
    rows[8] = '{6'h23, 6'h00, 1'b0, 2, 0, 7, 1, 4, 0, 0, 1'b0};  // lw, fetch waits
    rows[9] = '{6'h00, 6'h08, 1'b1, 0, 0, 3, 0, 1, 0, 0, 1'b1};  // jr to 0

    waitrequest = 1'b1;
    tick(); tick();
    chk("reset_outputs", dut_ctl, '0);
    reset_n = 1'b1;
    #4;
    chk("idle_outputs", dut_ctl, '0);
    tick();
    chk("fetch_after_reset", {mem_read, iord, active}, 3'b101);

    for (int i = 0; i < 9; i++) run_row($sformatf("row%0d", i), rows[i]);

    for (int n = 0; n < 60; n++) begin
      int k, fw, mw;
      logic [5:0] op, fn;
      k = $urandom_range(0, 7);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      fn = 6'($urandom_range(0, 63));
      case (k)
        0: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h08; end
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h09;
        5: op = 6'h04;
        6: op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      instr_opcode = op; instr_funct = fn;
      jr_target_zero = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      build(op, fn, fw, mw);
      foreach (exp_q[j]) begin
        waitrequest = exp_q[j].fixed ? exp_q[j].val : 1'($urandom_range(0, 1));
        #4;
        chk($sformatf("rand%0d_op%0h_cyc%0d", n, op, j), dut_ctl, exp_q[j].c);
        tick();
      end
    end

    // Reset while a data read is stalled.
    instr_opcode = 6'h23; instr_funct = 6'h00; waitrequest = 1'b0;
    tick();
    tick();
    tick();
    waitrequest = 1'b1;
    #2;
    chk("memrd_request", {mem_read, iord}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_read", mem_read, 1'b0);
    chk("reset_all_zero", dut_ctl, '0);
    tick();
    tick();
    reset_n = 1'b1;
    #4;
    chk("idle_after_release", dut_ctl, '0);
    tick();
    chk("fetch_after_release", {mem_read, iord, active}, 3'b101);

    run_row("jr_halt", rows[9]);
    for (int i = 0; i < 6; i++) begin
      waitrequest = 1'(i % 2);
      #4;
      chk("halt_hold", dut_ctl, '0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
